c2f_chunk_streamer: RTL and testbench

- Parametrised successor to the CPU->FPGA chunk consumer.
- Watches the producer's ring write index and reads each complete chunk out of the C2F burst-write RAM (fixed read latency).
- Presents each chunk as a valid/ready beat stream with start-of-packet (SOP) and end-of-packet (EOP) markers, and owns the ring read index.
- Pulses dtAck when a chunk has been fully handed downstream. Adds downstream backpressure, selectable RAM latency, an enable gate and an occupancy output.

---
 rtl/c2f_chunk_streamer.sv | 201 ++++++++++++++++++++
 tb/tb_c2f_chunk_streamer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/c2f_chunk_streamer.sv
// Streams complete ring chunks out of the C2F burst-write RAM as a valid/ready
// beat stream with SOP/EOP markers; owns the ring read index and acks each chunk.
module c2f_chunk_streamer #(
  parameter int INDEX_NBITS  = 6,
  parameter int OFFSET_NBITS = 4,
  parameter int DATA_NBITS   = 64,
  parameter int RD_LATENCY   = 1,
  parameter int HOLDOFF_INIT = 128,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    sysClk,
  input  logic                    sysRst_n,
  input  logic                    enable,
  input  logic [INDEX_NBITS-1:0]  wrIndex,
  output logic [INDEX_NBITS-1:0]  rdIndex,
  output logic [OFFSET_NBITS-1:0] rdOffset,
  input  logic [DATA_NBITS-1:0]   rdData,
  output logic                    dtAck,
  output logic [INDEX_NBITS-1:0]  pending,
  output logic [DATA_NBITS-1:0]   outData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    outSop,
  output logic                    outEop
);

  localparam int HCNT_W = (HOLDOFF_INIT > 0) ? $clog2(HOLDOFF_INIT + 1) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W  = DATA_NBITS + 2;
  localparam logic [OFFSET_NBITS-1:0] OFS_LAST = '1;
  localparam logic [FCNT_W:0]         DEPTH_C  = (FCNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]        PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_HOLDOFF = 2'd0,
    ST_IDLE    = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [HCNT_W-1:0]       hcnt_q, hcnt_d;
  logic [INDEX_NBITS-1:0]  rd_index_q, rd_index_d;
  logic [INDEX_NBITS-1:0]  pending_q, pending_d;
  logic [OFFSET_NBITS-1:0] rd_offset_q, rd_offset_d;
  logic                    dt_ack_q, dt_ack_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d, sop_tag_q, sop_tag_d, eop_tag_q, eop_tag_d;
  logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;

  logic [FCNT_W-1:0]       in_flight_s;
  logic [FCNT_W:0]         occ_s;
  logic                    issue_s, push_s, pop_s;
  logic [ENT_W-1:0]        head_s;

  assign head_s   = mem_q[rd_ptr_q];
  assign outValid = (fifo_cnt_q != '0);
  assign outData  = head_s[DATA_NBITS-1:0];
  assign outSop   = head_s[DATA_NBITS];
  assign outEop   = head_s[DATA_NBITS+1];
  assign rdIndex  = rd_index_q;
  assign rdOffset = rd_offset_q;
  assign dtAck    = dt_ack_q;
  assign pending  = pending_q;

  assign pop_s  = outValid & outReady;
  assign push_s = vld_q[RD_LATENCY-1];

  // Credit counts reads still in the RAM pipe so the FIFO can never overflow.
  always_comb begin
    in_flight_s = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight_s = in_flight_s + FCNT_W'(vld_q[i]);
    end
    occ_s = {1'b0, fifo_cnt_q} + {1'b0, in_flight_s};
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    rd_index_d  = rd_index_q;
    rd_offset_d = rd_offset_q;
    dt_ack_d    = 1'b0;
    issue_s     = 1'b0;
    case (state_q)
      ST_HOLDOFF: begin
        if (hcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hcnt_d = hcnt_q - HCNT_W'(1);
        end
      end
      ST_IDLE: begin
        rd_offset_d = '0;
        if (enable && (pending_q != '0)) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (occ_s < DEPTH_C) begin
          issue_s     = 1'b1;
          rd_offset_d = rd_offset_q + OFFSET_NBITS'(1);
          if (rd_offset_q == OFS_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        // Chunk is only released once its last beat has left downstream.
        if (pop_s && head_s[DATA_NBITS+1]) begin
          dt_ack_d   = 1'b1;
          rd_index_d = rd_index_q + INDEX_NBITS'(1);
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_HOLDOFF;
      end
    endcase
    pending_d = wrIndex - rd_index_d;
  end

  always_comb begin
    vld_d[0]     = issue_s;
    sop_tag_d[0] = (rd_offset_q == '0);
    eop_tag_d[0] = (rd_offset_q == OFS_LAST);
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]     = vld_q[i-1];
      sop_tag_d[i] = sop_tag_q[i-1];
      eop_tag_d[i] = eop_tag_q[i-1];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {eop_tag_q[RD_LATENCY-1], sop_tag_q[RD_LATENCY-1], rdData};
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q     <= ST_HOLDOFF;
      hcnt_q      <= HCNT_W'(HOLDOFF_INIT);
      rd_index_q  <= '0;
      pending_q   <= '0;
      rd_offset_q <= '0;
      dt_ack_q    <= 1'b0;
      vld_q       <= '0;
      sop_tag_q   <= '0;
      eop_tag_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      rd_index_q  <= rd_index_d;
      pending_q   <= pending_d;
      rd_offset_q <= rd_offset_d;
      dt_ack_q    <= dt_ack_d;
      vld_q       <= vld_d;
      sop_tag_q   <= sop_tag_d;
      eop_tag_q   <= eop_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_c2f_chunk_streamer.sv
// Random-data bench for c2f_chunk_streamer: two instances (RAM latency 1 and 3)
// share stimulus and are checked against a chunk/beat reference model.
module tb_c2f_chunk_streamer;
  localparam int IW = 3;
  localparam int OW = 4;
  localparam int DW = 64;
  localparam int HO = 8;
  localparam int FD = 4;
  localparam int NRAM = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b1;
  logic [IW-1:0] wr_index = '0;
  logic          out_ready = 1'b1;

  logic [DW-1:0] ram [NRAM];
  logic [IW-1:0] rd_idx [2];
  logic [OW-1:0] rd_off [2];
  logic [DW-1:0] rd_data [2];
  logic          dt_ack [2];
  logic [IW-1:0] pend [2];
  logic [DW-1:0] o_data [2];
  logic          o_valid [2];
  logic          o_sop [2];
  logic          o_eop [2];
  logic [6:0]    pa [2][3];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int bp_ph = 0;
  bit gap_chk = 1'b0;
  bit quiet = 1'b0;
  logic [IW-1:0] wr_prev = '0;
  int lat [2] = '{1, 3};

  int exp_idx [2], exp_beat [2], since_rst [2], last_eop [2];
  bit ack_due [2], seen_vld [2], stall [2], have_eop [2];
  logic [DW-1:0] st_data [2];
  logic st_sop [2], st_eop [2];

  always #5 clk = ~clk;

  c2f_chunk_streamer #(.INDEX_NBITS(IW), .OFFSET_NBITS(OW), .DATA_NBITS(DW),
    .RD_LATENCY(1), .HOLDOFF_INIT(HO), .FIFO_DEPTH(FD)) u_dut_l1 (
    .sysClk(clk), .sysRst_n(rst_n), .enable(enable), .wrIndex(wr_index),
    .rdIndex(rd_idx[0]), .rdOffset(rd_off[0]), .rdData(rd_data[0]), .dtAck(dt_ack[0]),
    .pending(pend[0]), .outData(o_data[0]), .outValid(o_valid[0]), .outReady(out_ready),
    .outSop(o_sop[0]), .outEop(o_eop[0]));

  c2f_chunk_streamer #(.INDEX_NBITS(IW), .OFFSET_NBITS(OW), .DATA_NBITS(DW),
    .RD_LATENCY(3), .HOLDOFF_INIT(HO), .FIFO_DEPTH(FD)) u_dut_l3 (
    .sysClk(clk), .sysRst_n(rst_n), .enable(enable), .wrIndex(wr_index),
    .rdIndex(rd_idx[1]), .rdOffset(rd_off[1]), .rdData(rd_data[1]), .dtAck(dt_ack[1]),
    .pending(pend[1]), .outData(o_data[1]), .outValid(o_valid[1]), .outReady(out_ready),
    .outSop(o_sop[1]), .outEop(o_eop[1]));

  // RAM models: registered address pipelines of depth 1 and 3.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pa[d][0] <= {rd_idx[d], rd_off[d]};
      pa[d][1] <= pa[d][0];
      pa[d][2] <= pa[d][1];
    end
  end
  assign rd_data[0] = ram[pa[0][0]];
  assign rd_data[1] = ram[pa[1][2]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Downstream ready patterns: always, 1-0-0-1 repeating, or random 75%.
  always @(posedge clk) begin
    #1;
    bp_ph = (bp_ph + 1) % 4;
    case (rdy_mode)
      1:       out_ready = (bp_ph == 0) || (bp_ph == 3);
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Reference model: each consumed chunk is ram[idx*16 +: 16] in order, then one ack.
  always @(negedge clk) begin
    logic [6:0] ra;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_valid", 64'(o_valid[d]), 64'd0);
        chk("rst_rdidx", 64'(rd_idx[d]), 64'd0);
        chk("rst_ack", 64'(dt_ack[d]), 64'd0);
        exp_idx[d] = 0; exp_beat[d] = 0; ack_due[d] = 1'b0; since_rst[d] = 0;
        seen_vld[d] = 1'b0; stall[d] = 1'b0; have_eop[d] = 1'b0;
      end else begin
        since_rst[d]++;
        chk("ack", 64'(dt_ack[d]), 64'(ack_due[d]));
        ack_due[d] = 1'b0;
        chk("rdidx", 64'(rd_idx[d]), 64'(exp_idx[d]));
        if (since_rst[d] >= 2)
          chk("pending", 64'(pend[d]), 64'((int'(wr_prev) - exp_idx[d]) & 7));
        if (quiet) chk("quiet", 64'(o_valid[d]), 64'd0);
        if (o_valid[d] && !seen_vld[d]) begin
          seen_vld[d] = 1'b1;
          chk("holdoff", 64'(since_rst[d] > HO), 64'd1);
        end
        if (stall[d]) begin
          chk("stall_valid", 64'(o_valid[d]), 64'd1);
          chk("stall_data", o_data[d], st_data[d]);
          chk("stall_sop", 64'(o_sop[d]), 64'(st_sop[d]));
          chk("stall_eop", 64'(o_eop[d]), 64'(st_eop[d]));
        end
        stall[d] = o_valid[d] && !out_ready;
        st_data[d] = o_data[d]; st_sop[d] = o_sop[d]; st_eop[d] = o_eop[d];
        if (o_valid[d] && out_ready) begin
          chk("avail", 64'((exp_beat[d] != 0) || (exp_idx[d] != int'(wr_index))), 64'd1);
          ra = 7'(exp_idx[d] * 16 + exp_beat[d]);
          chk("data", o_data[d], ram[ra]);
          chk("sop", 64'(o_sop[d]), 64'(exp_beat[d] == 0));
          chk("eop", 64'(o_eop[d]), 64'(exp_beat[d] == 15));
          if (o_sop[d] && gap_chk && have_eop[d])
            chk("gap", 64'((cyc - last_eop[d]) <= lat[d] + 3), 64'd1);
          if (exp_beat[d] == 15) begin
            ack_due[d] = 1'b1;
            exp_idx[d] = (exp_idx[d] + 1) % 8;
            exp_beat[d] = 0;
            last_eop[d] = cyc;
            have_eop[d] = gap_chk;
          end else begin
            exp_beat[d]++;
          end
        end
        if (!gap_chk) have_eop[d] = 1'b0;
      end
    end
    wr_prev = wr_index;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idx(input int target, input int bound, input string tag);
    int n = 0;
    while (!(exp_idx[0] == target && exp_idx[1] == target) && n < bound) begin
      step(1);
      n++;
    end
    chk(tag, 64'(exp_idx[0] == target && exp_idx[1] == target), 64'd1);
  endtask

  task automatic wait_beat(input int target, input int bound, input string tag);
    int n = 0;
    while (exp_beat[0] != target && n < bound) begin
      step(1);
      n++;
    end
    chk(tag, 64'(exp_beat[0] == target), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < NRAM; i++) ram[i] = {$urandom, $urandom};
    wr_index = 3'd1;
    #2 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    wait_idx(1, 300, "holdoff_chunk");
    step(4);
    chk("idle_valid", 64'(o_valid[0]), 64'd0);

    gap_chk = 1'b1;
    wr_index = 3'd5;
    wait_idx(5, 400, "burst_done");
    gap_chk = 1'b0;

    rdy_mode = 1;
    wr_index = 3'd6;
    wait_idx(6, 400, "bp_done");

    rdy_mode = 2;
    wr_index = 3'd1;
    step(2);
    chk("wrap_pend_l1", 64'(pend[0]), 64'd3);
    chk("wrap_pend_l3", 64'(pend[1]), 64'd3);
    wait_idx(1, 800, "wrap_done");

    rdy_mode = 0;
    step(2);
    enable = 1'b0;
    wr_index = 3'd3;
    quiet = 1'b1;
    step(50);
    quiet = 1'b0;
    enable = 1'b1;
    wait_beat(5, 100, "en_start");
    enable = 1'b0;
    wait_idx(2, 200, "en_chunk_done");
    quiet = 1'b1;
    step(50);
    quiet = 1'b0;
    chk("en_hold_l1", 64'(rd_idx[0]), 64'd2);
    chk("en_hold_l3", 64'(rd_idx[1]), 64'd2);

    enable = 1'b1;
    wait_beat(5, 100, "rst_start");
    rst_n = 1'b0;
    wr_index = 3'd1;
    step(3);
    rst_n = 1'b1;
    wait_idx(1, 300, "rst_restream");
    step(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
